// File: rtl/keypad_debounce.sv
// Keypad front end: synchronises the raw valid/code lines, debounces press and
// release, and emits one classified strobe per accepted key press.
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset_n,
    input  logic       key_validin,
    input  logic [3:0] key_code,
    output logic       key_strobe,
    output logic [3:0] key_value,
    output logic       is_digit,
    output logic       is_enter,
    output logic       is_cancel,
    output logic       key_held
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t                          state_q, state_d;
    logic [SYNC_STAGES-1:0]          vsync_q, vsync_d;
    logic [SYNC_STAGES-1:0][3:0]     csync_q, csync_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [3:0]                      cand_q, cand_d;
    logic [3:0]                      key_value_q, key_value_d;
    logic                            strobe_q, strobe_d;
    logic                            digit_q, digit_d;
    logic                            enter_q, enter_d;
    logic                            cancel_q, cancel_d;
    logic                            valid_s;
    logic [3:0]                      code_s;

    always_comb begin
        vsync_d = {vsync_q[SYNC_STAGES-2:0], key_validin};
        csync_d = {csync_q[SYNC_STAGES-2:0], key_code};
    end

    assign valid_s = vsync_q[SYNC_STAGES-1];
    assign code_s  = csync_q[SYNC_STAGES-1];

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vsync_q     <= '0;
            csync_q     <= '0;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_value_q <= '0;
            strobe_q    <= 1'b0;
            digit_q     <= 1'b0;
            enter_q     <= 1'b0;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            csync_q     <= csync_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_value_q <= key_value_d;
            strobe_q    <= strobe_d;
            digit_q     <= digit_d;
            enter_q     <= enter_d;
            cancel_q    <= cancel_d;
        end
    end

    // The counter only advances below CNT_LAST, so it can never wrap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_value_d = key_value_q;
        strobe_d    = 1'b0;
        digit_d     = 1'b0;
        enter_d     = 1'b0;
        cancel_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                    cand_d  = code_s;
                end
            end
            PRESS_DB: begin
                if (!valid_s) begin
                    state_d = IDLE;
                end else if (code_s != cand_q) begin
                    cand_d = code_s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    key_value_d = cand_q;
                    strobe_d    = 1'b1;
                    enter_d     = (cand_q == 4'hE);
                    cancel_d    = (cand_q == 4'hF);
                    digit_d     = (cand_q != 4'hE) && (cand_q != 4'hF);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!valid_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
            end
            RELEASE_DB: begin
                if (valid_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        key_held   = (state_q == HELD) || (state_q == RELEASE_DB);
        key_strobe = strobe_q;
        key_value  = key_value_q;
        is_digit   = digit_q;
        is_enter   = enter_q;
        is_cancel  = cancel_q;
    end
endmodule

// File: tb/tb_keypad_debounce.sv
// Directed + random bench for keypad_debounce, checked cycle by cycle against a
// run-length model of the debounce rules.
module tb_keypad_debounce;
    localparam int D = 8;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_validin;
    logic [3:0] key_code;
    logic       key_strobe, is_digit, is_enter, is_cancel, key_held;
    logic [3:0] key_value;

    keypad_debounce #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .MAX10_CLK1_50(clk), .reset_n(reset_n), .key_validin(key_validin),
        .key_code(key_code), .key_strobe(key_strobe), .key_value(key_value),
        .is_digit(is_digit), .is_enter(is_enter), .is_cancel(is_cancel),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    int edge_no = 0, n_strobe = 0, n_held_fall = 0;
    int last_strobe_edge = -1, held_fall_edge = -1;
    logic [2:0] last_flags = '0;
    logic prev_held = 1'b0;

    // model: pin samples delayed by the synchroniser, then run lengths
    logic [4:0] pin_q[$];
    bit held = 0;
    int run1 = 0, run0 = 0;
    logic [3:0] run_code = '0, m_value = '0;
    logic m_strobe = 1'b0;
    logic [2:0] m_flags = '0;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
    endtask

    task automatic model_edge();
        logic sv;
        logic [3:0] sc;
        m_strobe = 1'b0;
        m_flags  = '0;
        if (!reset_n) begin
            pin_q.delete();
            held = 0; run1 = 0; run0 = 0; m_value = '0;
            return;
        end
        if (pin_q.size() == S) {sv, sc} = pin_q.pop_front();
        else begin sv = 1'b0; sc = '0; end
        pin_q.push_back({key_validin, key_code});
        if (!held) begin
            if (sv) begin
                if (run1 > 0 && sc == run_code) run1++;
                else begin run1 = 1; run_code = sc; end
                if (run1 == D + 1) begin
                    held = 1; run1 = 0; run0 = 0;
                    m_strobe = 1'b1; m_value = sc;
                    m_flags = (sc == 4'hE) ? 3'b010 : (sc == 4'hF) ? 3'b001 : 3'b100;
                end
            end else run1 = 0;
        end else begin
            if (!sv) begin
                run0++;
                if (run0 == D + 1) begin held = 0; run0 = 0; end
            end else run0 = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        edge_no++;
        check("strobe", {3'b0, key_strobe}, {3'b0, m_strobe});
        check("value", key_value, m_value);
        check("flags", {1'b0, is_digit, is_enter, is_cancel}, {1'b0, m_flags});
        check("held", {3'b0, key_held}, {3'b0, held});
        if (key_strobe) begin
            n_strobe++;
            last_strobe_edge = edge_no;
            last_flags = {is_digit, is_enter, is_cancel};
            check("onehot", 4'($countones({is_digit, is_enter, is_cancel})), 4'd1);
        end
        if (prev_held && !key_held) begin n_held_fall++; held_fall_edge = edge_no; end
        prev_held = key_held;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int p, f, c, s0, h0;
        reset_n = 1'b0; key_validin = 1'b0; key_code = '0;
        #1;
        check("rst_outs", {key_strobe, is_digit, is_enter, is_cancel}, 4'h0);
        check("rst_val_held", {key_held, key_value[2:0]}, 4'h0);
        cyc(3);
        reset_n = 1'b1;
        cyc(4);

        // 1: clean press of 5
        s0 = n_strobe; key_code = 4'h5; key_validin = 1'b1; p = edge_no + 1;
        cyc(30);
        key_validin = 1'b0; f = edge_no + 1;
        cyc(20);
        check("t1_count", 4'(n_strobe - s0), 4'd1);
        check("t1_lat", 4'(last_strobe_edge - p + 1), 4'(S + D + 1));
        check("t1_rel", 4'(held_fall_edge - (f + 1)), 4'(D + 1));
        check("t1_flags", {1'b0, last_flags}, 4'b0100);

        // 2: short glitch
        s0 = n_strobe; key_code = 4'h3; key_validin = 1'b1;
        cyc(5);
        key_validin = 1'b0;
        cyc(15);
        check("t2_count", 4'(n_strobe - s0), 4'd0);
        check("t2_value", key_value, 4'h5);

        // 3: bouncy press and release of #
        s0 = n_strobe; key_code = 4'hE;
        key_validin = 1'b1; cyc(3);
        key_validin = 1'b0; cyc(2);
        key_validin = 1'b1; cyc(30);
        h0 = n_held_fall;
        key_validin = 1'b0; cyc(2);
        key_validin = 1'b1; cyc(2);
        check("t3_bounce_held", {3'b0, key_held}, 4'd1);
        check("t3_bounce_nofall", 4'(n_held_fall - h0), 4'd0);
        key_validin = 1'b0; cyc(20);
        check("t3_count", 4'(n_strobe - s0), 4'd1);
        check("t3_flags", {1'b0, last_flags}, 4'b0010);

        // 4: code change mid-debounce
        s0 = n_strobe; key_code = 4'h3; key_validin = 1'b1;
        cyc(4);
        key_code = 4'h7; c = edge_no + 1;
        cyc(20);
        key_validin = 1'b0;
        cyc(20);
        check("t4_count", 4'(n_strobe - s0), 4'd1);
        check("t4_value", key_value, 4'h7);
        check("t4_lat", 4'(last_strobe_edge - (c + S - 1)), 4'(D + 1));

        // 5: reset while held, valid stays high
        key_code = 4'hF; key_validin = 1'b1;
        cyc(16);
        check("t5_pre_held", {3'b0, key_held}, 4'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_outs", {key_strobe, is_digit, is_enter, is_cancel}, 4'h0);
        check("t5_rst_value", key_value, 4'h0);
        check("t5_rst_held", {3'b0, key_held}, 4'd0);
        cyc(3);
        s0 = n_strobe; reset_n = 1'b1; p = edge_no + 1;
        cyc(20);
        key_validin = 1'b0;
        cyc(20);
        check("t5_count", 4'(n_strobe - s0), 4'd1);
        check("t5_flags", {1'b0, last_flags}, 4'b0001);
        check("t5_lat", 4'(last_strobe_edge - p + 1), 4'(S + D + 1));

        // 6: classification sweep
        s0 = n_strobe;
        for (int k = 0; k < 16; k++) begin
            key_code = 4'(k); key_validin = 1'b1;
            cyc(12);
            check("t6_value", key_value, 4'(k));
            check("t6_flags", {1'b0, last_flags},
                  {1'b0, (k == 14) ? 3'b010 : (k == 15) ? 3'b001 : 3'b100});
            key_validin = 1'b0;
            cyc(12);
        end
        check("t6_count", 5'(n_strobe - s0) == 5'd16 ? 4'd1 : 4'd0, 4'd1);

        // random bursts, some with a code change partway through
        for (int k = 0; k < 80; k++) begin
            int len1;
            len1 = $urandom_range(1, 14);
            key_code = 4'($urandom); key_validin = 1'b1;
            for (int j = 0; j < len1; j++) begin
                if ($urandom_range(0, 15) == 0) key_code = 4'($urandom);
                step();
            end
            key_validin = 1'b0;
            cyc($urandom_range(1, 14));
        end
        key_validin = 1'b0;
        cyc(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
